// File: rtl/vend_coin_collector.sv
// Coin collector ahead of change_machine: accumulates payment against a latched cost
// and keeps the coin inventory. Optional idle refund in COLLECT: define COLLECT_TIMEOUT_EN.
module vend_coin_collector #(
  parameter int unsigned INV_MAX        = 3,
  parameter int unsigned INV_INIT       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       item_valid,
  input  logic [3:0] item_cost,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       change_ack,
  input  logic [2:0] first_coin,
  input  logic [2:0] second_coin,
  output logic [3:0] cost,
  output logic [3:0] paid,
  output logic [1:0] quarters,
  output logic [1:0] dimes,
  output logic [1:0] nickels,
  output logic       txn_valid,
  output logic       busy,
  output logic       coin_reject
);

  if (INV_MAX > 3 || INV_INIT > INV_MAX || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
  begin : g_bad_config
    $error("vend_coin_collector: invalid parameter combination");
  end

  localparam logic [1:0] INV_MAX_L  = 2'(INV_MAX);
  localparam logic [1:0] INV_INIT_L = 2'(INV_INIT);

  typedef enum logic [1:0] {IDLE, COLLECT, SETTLE} state_e;

  state_e     state_q, state_d;
  logic [3:0] cost_q, cost_d;
  logic [3:0] paid_q, paid_d;
  logic [1:0] quarters_q, quarters_d;
  logic [1:0] dimes_q, dimes_d;
  logic [1:0] nickels_q, nickels_d;
  logic       reject_q, reject_d;

  logic [3:0] coin_val;
  logic [4:0] paid_sum;
  logic       timeout;
  logic       abort;
  logic       coin_ok;
  logic [1:0] deb_q, deb_d, deb_n;

  function automatic logic [1:0] sat_inc(input logic [1:0] inv);
    return (inv >= INV_MAX_L) ? inv : inv + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] inv, input logic [1:0] n);
    return (inv > n) ? inv - n : 2'd0;
  endfunction

  always_comb begin
    coin_val = 4'd0;
    case (coin_type)
      2'b01:   coin_val = 4'd1;
      2'b10:   coin_val = 4'd2;
      2'b11:   coin_val = 4'd5;
      default: coin_val = 4'd0;
    endcase
  end

`ifdef COLLECT_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign timeout = (state_q == COLLECT) && (tmo_q == 8'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_d = tmo_q + 8'd1;
    if (state_q != COLLECT || coin_ok) tmo_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 8'd0;
    else        tmo_q <= tmo_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Cancel (or timeout) wins over a coin presented in the same cycle.
  assign paid_sum = {1'b0, paid_q} + {1'b0, coin_val};
  assign abort    = (state_q == COLLECT) && (cancel || timeout);
  assign coin_ok  = (state_q == COLLECT) && coin_valid && (coin_type != 2'b00) &&
                    !abort && (paid_sum <= 5'd15);

  // Identical coins count twice; 0 and any unlisted value debit nothing.
  assign deb_q = {1'b0, first_coin == 3'd5} + {1'b0, second_coin == 3'd5};
  assign deb_d = {1'b0, first_coin == 3'd2} + {1'b0, second_coin == 3'd2};
  assign deb_n = {1'b0, first_coin == 3'd1} + {1'b0, second_coin == 3'd1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cost_q     <= 4'd0;
      paid_q     <= 4'd0;
      quarters_q <= INV_INIT_L;
      dimes_q    <= INV_INIT_L;
      nickels_q  <= INV_INIT_L;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cost_q     <= cost_d;
      paid_q     <= paid_d;
      quarters_q <= quarters_d;
      dimes_q    <= dimes_d;
      nickels_q  <= nickels_d;
      reject_q   <= reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (item_valid) state_d = (item_cost == 4'd0) ? SETTLE : COLLECT;
      COLLECT: if (abort || (coin_ok && paid_sum[3:0] >= cost_q)) state_d = SETTLE;
      SETTLE:  if (change_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cost_d     = cost_q;
    paid_d     = paid_q;
    quarters_d = quarters_q;
    dimes_d    = dimes_q;
    nickels_d  = nickels_q;
    reject_d   = coin_valid && !coin_ok;
    case (state_q)
      IDLE: begin
        if (item_valid) begin
          cost_d = item_cost;
          paid_d = 4'd0;
        end
      end
      COLLECT: begin
        if (abort) begin
          cost_d = 4'd0;
        end else if (coin_ok) begin
          paid_d = paid_sum[3:0];
          case (coin_type)
            2'b01:   nickels_d  = sat_inc(nickels_q);
            2'b10:   dimes_d    = sat_inc(dimes_q);
            2'b11:   quarters_d = sat_inc(quarters_q);
            default: ;
          endcase
        end
      end
      SETTLE: begin
        if (change_ack) begin
          quarters_d = sat_dec(quarters_q, deb_q);
          dimes_d    = sat_dec(dimes_q, deb_d);
          nickels_d  = sat_dec(nickels_q, deb_n);
          cost_d     = 4'd0;
          paid_d     = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    txn_valid = (state_q == SETTLE);
    busy      = (state_q != IDLE);
  end

  assign cost        = cost_q;
  assign paid        = paid_q;
  assign quarters    = quarters_q;
  assign dimes       = dimes_q;
  assign nickels     = nickels_q;
  assign coin_reject = reject_q;

endmodule

// File: doc/vend_coin_collector.md
Name: vend_coin_collector

Overview:
- Upstream stage of change_machine: accepts one coin per cycle, accumulates the amount paid against a latched item cost, and tracks the on-hand coin inventory.
- Presents a stable {cost, paid, quarters, dimes, nickels} transaction to change_machine.
- Holds the transaction until the dispenser acknowledges with the two coins actually issued, then debits those coins from inventory.
- All amounts are in nickels, 4-bit unsigned.

Parameters:
INV_MAX, 3, saturation ceiling of each coin inventory counter; must fit 2 bits
INV_INIT, 2, reset value of each inventory counter; must be <= INV_MAX
TIMEOUT_CYCLES, 255, idle cycles in COLLECT before automatic refund (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
item_valid  in  1  item selection strobe; sampled in IDLE only
item_cost  in  4  cost of the selected item in nickels
coin_valid  in  1  coin inserted this cycle
coin_type  in  2  01 = nickel (1), 10 = dime (2), 11 = quarter (5); 00 is illegal
cancel  in  1  customer abort, full refund
change_ack  in  1  dispenser has issued the change for the current transaction
first_coin  in  3  coin issued first; values 5, 2, 1 or 0
second_coin  in  3  coin issued second; values 5, 2, 1 or 0
cost  out  4  latched cost; forced to 0 on refund
paid  out  4  accumulated payment
quarters  out  2  quarter inventory
dimes  out  2  dime inventory
nickels  out  2  nickel inventory
txn_valid  out  1  transaction stable and ready for change computation
busy  out  1  state != IDLE
coin_reject  out  1  one-cycle pulse: the coin in the previous cycle was not accepted

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE
  - cost = 0, paid = 0
  - quarters = dimes = nickels = INV_INIT
  - txn_valid = 0, busy = 0, coin_reject = 0
  - Reset mid-transaction discards that transaction.
- States:
  - IDLE: on item_valid, cost <= item_cost and paid <= 0.
    - If item_cost == 0, go to SETTLE; otherwise go to COLLECT.
  - COLLECT: a coin is accepted when coin_valid, coin_type != 00, cancel = 0, and paid + value <= 15.
    - On acceptance, paid <= paid + value.
    - The matching inventory counter increments and saturates at INV_MAX; excess coins go to the cashbox and are not counted.
    - If the new paid >= cost, go to SETTLE on the same edge.
    - Otherwise coin_reject pulses on the next cycle and paid is unchanged.
    - cancel has priority over a coin in the same cycle: the coin is rejected, cost <= 0, paid is kept, go to SETTLE.
  - SETTLE: txn_valid = 1.
    - cost, paid and the inventory counts are frozen.
    - On change_ack, decrement the inventory for first_coin and for second_coin. Two identical coins decrement that counter by 2. Counters saturate at 0, and a value of 0 decrements nothing.
    - Then cost <= 0, paid <= 0, go to IDLE. txn_valid drops in the next cycle.
- coin_valid in IDLE or SETTLE: always rejected, coin_reject pulses.
- item_valid outside IDLE: ignored.
- change_ack outside SETTLE: ignored.
- Combinational outputs: txn_valid and busy decode from state only.
- Registered outputs: all other outputs; no other combinational input-to-output paths.
- Latency:
  - Coin to paid update: 1 cycle.
  - Final coin to txn_valid: 1 cycle.
  - change_ack to IDLE: 1 cycle.

Optional Feature:
COLLECT_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs in COLLECT, cleared on entry and on every accepted coin.
  - When it reaches TIMEOUT_CYCLES, the block performs the same action as cancel: cost <= 0, go to SETTLE.
- Undefined: no counter; COLLECT waits indefinitely.

Test Plan:
- Reset with INV_INIT = 2 -> all inventories 2, cost = 0, paid = 0, txn_valid = 0, busy = 0.
- item_cost = 8, then dime, quarter, quarter -> paid 2, 7, 12. txn_valid rises 1 cycle after the last coin with cost = 8, paid = 12. quarters = 3 (saturated), dimes = 3.
- In SETTLE with quarters = 3, dimes = 3, nickels = 2: change_ack with first_coin = 2, second_coin = 2 -> dimes = 1, state IDLE, paid = 0, cost = 0.
- item_cost = 15, paid = 12, quarter inserted -> coin_reject pulse, paid stays 12. Then cancel and a nickel in the same cycle -> coin rejected, cost = 0, paid = 12, txn_valid = 1.
- item_cost = 0 -> SETTLE directly with paid = 0 and cost = 0. coin_valid in SETTLE -> coin_reject. Deassert rst_n mid-SETTLE -> immediate IDLE with reset values.
- With COLLECT_TIMEOUT_EN, TIMEOUT_CYCLES = 10: item_cost = 6, one nickel, then no coins -> SETTLE after 10 cycles with cost = 0, paid = 1. Without the macro, still COLLECT after 1000 cycles.
